// File: rtl/main_fsm.sv
// Moore main controller for the multicycle ARM datapath.
// Steps each instruction through fetch/decode/execute/memory/writeback and drives mux selects.
module main_fsm #(
    parameter int unsigned STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         Op,
    input  logic [5:0]         Funct,
    output logic               IRWrite,
    output logic               AdrSrc,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ResultSrc,
    output logic               NextPC,
    output logic               RegW,
    output logic               MemW,
    output logic               Branch,
    output logic               ALUOp,
    output logic               IllegalOp,
    output logic [STATE_W-1:0] State
);

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAdr  = 4'd2,
        StMemRd   = 4'd3,
        StMemWb   = 4'd4,
        StMemWr   = 4'd5,
        StExecR   = 4'd6,
        StExecI   = 4'd7,
        StAluWb   = 4'd8,
        StBranch  = 4'd9,
        StUnknown = 4'd10
    } state_t;

    state_t stateQ, stateD;

    // Only the I and L/S bits of Funct steer the sequence.
    logic unusedFunct;
    assign unusedFunct = ^Funct[4:1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateQ <= StFetch;
        end else begin
            stateQ <= stateD;
        end
    end

    always_comb begin
        stateD = StFetch;
        unique case (stateQ)
            StFetch:  stateD = StDecode;
            StDecode: begin
                unique case (Op)
                    2'b00:   stateD = Funct[5] ? StExecI : StExecR;
                    2'b01:   stateD = StMemAdr;
                    2'b10:   stateD = StBranch;
                    default: stateD = StUnknown;
                endcase
            end
            StMemAdr: stateD = Funct[0] ? StMemRd : StMemWr;
            StMemRd:  stateD = StMemWb;
            StExecR:  stateD = StAluWb;
            StExecI:  stateD = StAluWb;
            // MemWb, MemWr, AluWb, Branch, Unknown and unreachable codes all return to fetch.
            default:  stateD = StFetch;
        endcase
    end

    always_comb begin
        IRWrite   = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        NextPC    = 1'b0;
        RegW      = 1'b0;
        MemW      = 1'b0;
        Branch    = 1'b0;
        ALUOp     = 1'b0;
        IllegalOp = 1'b0;
        unique case (stateQ)
            StFetch: begin
                IRWrite   = 1'b1;
                NextPC    = 1'b1;
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            StDecode: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            StMemAdr: ALUSrcB = 2'b01;
            StMemRd:  AdrSrc = 1'b1;
            StMemWb: begin
                ResultSrc = 2'b01;
                RegW      = 1'b1;
            end
            StMemWr: begin
                AdrSrc = 1'b1;
                MemW   = 1'b1;
            end
            StExecR:  ALUOp = 1'b1;
            StExecI: begin
                ALUSrcB = 2'b01;
                ALUOp   = 1'b1;
            end
            StAluWb:  RegW = 1'b1;
            StBranch: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                Branch    = 1'b1;
            end
            // Unknown and codes 11..15: flag only, no strobes.
            default:  IllegalOp = 1'b1;
        endcase
    end

    assign State = STATE_W'(stateQ);

endmodule
